cluster_clock_gate_ctrl: RTL
============================

# cluster_clock_gate_ctrl

Generates the enable for the cluster clock-gating cell from a four-phase request/acknowledge handshake with the power/SoC controller. Runs on the ungated reference clock. It opens the gate, waits a fixed settling time before acknowledging, and closes the gate only after all cluster busy sources have been idle for a programmable number of consecutive cycles. Its `clk_gate_en_o` drives the `en_i` input of `cluster_clock_gating` in the cluster top.

## Interface
- `NB_BUSY`, 4: number of busy sources (cores, DMA, interconnect, ...); ≥1.
- `WAKE_CYCLES`, 4: cycles from gate-open to acknowledge; ≥1.
- `IDLE_CYCLES`, 8: consecutive all-idle cycles needed before gate-close; ≥1.
- `clk_i`  in  1  ungated reference clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `clk_en_req_i`  in  1  request for cluster clock; level, four-phase.
- `busy_i`  in  NB_BUSY  per-source busy flags; synchronous to `clk_i`.
- `clk_gate_en_o`  out  1  registered enable to the gating cell.
- `clk_en_ack_o`  out  1  registered acknowledge.
- `cluster_off_o`  out  1  registered; 1 when state is CG_OFF.
- `state_o`  out  2  current FSM state (cg_state_e), for debug and status.

## Operation
- States: CG_OFF, CG_WAKE, CG_ON, CG_DRAIN. The block has one counter, `cnt`, with width $clog2(max(WAKE_CYCLES, IDLE_CYCLES)+1).
- Output values per state:
  - CG_OFF: gate_en=0, ack=0, off=1.
  - CG_WAKE: gate_en=1, ack=0, off=0.
  - CG_ON and CG_DRAIN: gate_en=1, ack=1, off=0.
- Transitions (from state, on condition):
  - CG_OFF, req=1: go to CG_WAKE, cnt←0.
  - CG_WAKE: cnt increments each cycle. When cnt==WAKE_CYCLES-1, go to CG_ON. Req is ignored in WAKE; if it drops during WAKE, the block still completes WAKE, enters ON, then DRAIN.
  - CG_ON, req=0: go to CG_DRAIN, cnt←0.
  - CG_DRAIN, req=1: go to CG_ON, cnt←0. This is a cancel; ack stays 1 throughout.
  - CG_DRAIN, req=0 and any busy: cnt←0.
  - CG_DRAIN, req=0 and no busy: if cnt==IDLE_CYCLES-1, go to CG_OFF; else cnt increments.
- The counter never wraps. It is only compared for equality and is cleared on every state entry.
- Busy asserted in CG_OFF or CG_WAKE is ignored.

## Timing
- All outputs come straight from flops, with no combinational path from any input to any output.
- Reset: state=CG_OFF, cnt=0, clk_gate_en_o=0, clk_en_ack_o=0, cluster_off_o=1, state_o=2'b00. All take effect asynchronously on rst_ni low.
- Reset while the block is in ON, WAKE or DRAIN drops gate_en immediately, without draining.
- Wake latency: req is sampled high at edge k. gate_en=1 after edge k. ack=1 after edge k+WAKE_CYCLES.
- Sleep latency: req is sampled low at edge m and busy stays low. gate_en=0 and ack=0 both after edge m+IDLE_CYCLES.
  - Each busy pulse restarts the idle window.
- gate_en and ack fall on the same edge, so ack=0 guarantees the clock is already gated.
- Cancel latency: req re-rises during DRAIN and is sampled at edge n. The block is in ON after edge n, and ack never deasserts.
- Busy and req=1 in the same DRAIN cycle: the req branch has priority.

## Structure
- Package `cluster_cg_pkg` holds:
  - `typedef enum logic [1:0] cg_state_e`, with CG_OFF=2'b00, CG_WAKE=2'b01, CG_ON=2'b10, CG_DRAIN=2'b11.
  - Default localparams for WAKE_CYCLES and IDLE_CYCLES.
- Single flat module with one FSM and one counter; no sub-module.
- Parameter checks, as elaboration assertions: NB_BUSY≥1, WAKE_CYCLES≥1, IDLE_CYCLES≥1.
- The cluster top instantiates `cluster_clock_gating` beside this block and connects its `en_i` to `clk_gate_en_o`.

## Test plan
- Reset with defaults: all outputs at their reset values. Then req=1 at edge 5: gate_en=1 after edge 5, ack=1 after edge 9, state_o=CG_ON.
- Sleep with no activity: req drops at edge 20, busy=0: gate_en=0, ack=0, cluster_off_o=1 after edge 28 (IDLE_CYCLES=8).
- Busy restart: in DRAIN, busy_i[2] pulses at the 5th idle cycle. The gate stays open until 8 consecutive idle cycles follow the pulse.
- Cancel: req drops, then rises again 3 cycles later. state_o goes DRAIN then ON, ack stays 1 continuously, and gate_en never falls.
- Reset mid-operation: rst_ni is asserted low mid-cycle while in CG_ON. gate_en and ack drop without waiting for a clock edge, and the state returns to CG_OFF.
- Parameter corners (WAKE_CYCLES=1, IDLE_CYCLES=1): ack rises 1 cycle after the req sample, and the gate closes 1 cycle after req=0 with busy=0.

Source files
------------

// File: rtl/cluster_cg_pkg.sv
// Shared types and defaults for the cluster clock-gate controller.
// The counter width helper sizes the single wake/idle counter.
package cluster_cg_pkg;

  typedef enum logic [1:0] {
    CG_OFF   = 2'b00,
    CG_WAKE  = 2'b01,
    CG_ON    = 2'b10,
    CG_DRAIN = 2'b11
  } cg_state_e;

  localparam int unsigned WAKE_CYCLES_DEF = 4;
  localparam int unsigned IDLE_CYCLES_DEF = 8;

  function automatic int unsigned cg_cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/cluster_clock_gate_ctrl.sv
// Four-phase req/ack controller driving the cluster clock-gate enable.
// Opens the gate, acknowledges after a settle time, closes after a busy-free idle window.
module cluster_clock_gate_ctrl
  import cluster_cg_pkg::*;
#(
  parameter int unsigned NB_BUSY     = 4,
  parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clk_en_req_i,
  input  logic [NB_BUSY-1:0] busy_i,
  output logic               clk_gate_en_o,
  output logic               clk_en_ack_o,
  output logic               cluster_off_o,
  output logic [1:0]         state_o
);

  localparam int unsigned CNT_W = cg_cnt_width(WAKE_CYCLES, IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  if (NB_BUSY < 1) begin : gen_chk_nb_busy
    $error("cluster_clock_gate_ctrl: NB_BUSY must be >= 1");
  end
  if (WAKE_CYCLES < 1) begin : gen_chk_wake
    $error("cluster_clock_gate_ctrl: WAKE_CYCLES must be >= 1");
  end
  if (IDLE_CYCLES < 1) begin : gen_chk_idle
    $error("cluster_clock_gate_ctrl: IDLE_CYCLES must be >= 1");
  end

  cg_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_en_q, gate_en_d;
  logic             ack_q, ack_d;
  logic             off_q, off_d;

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CG_OFF;
      cnt_q     <= '0;
      gate_en_q <= 1'b0;
      ack_q     <= 1'b0;
      off_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gate_en_q <= gate_en_d;
      ack_q     <= ack_d;
      off_q     <= off_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CG_OFF: begin
        if (clk_en_req_i) begin
          state_d = CG_WAKE;
          cnt_d   = '0;
        end
      end
      CG_WAKE: begin
        // Request is deliberately ignored here; a dropped req is handled from ON.
        if (cnt_q == WAKE_LAST) begin
          state_d = CG_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CG_ON: begin
        if (!clk_en_req_i) begin
          state_d = CG_DRAIN;
          cnt_d   = '0;
        end
      end
      CG_DRAIN: begin
        if (clk_en_req_i) begin
          state_d = CG_ON;
          cnt_d   = '0;
        end else if (|busy_i) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = CG_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = CG_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    gate_en_d = 1'b1;
    ack_d     = 1'b1;
    off_d     = 1'b0;
    unique case (state_d)
      CG_OFF: begin
        gate_en_d = 1'b0;
        ack_d     = 1'b0;
        off_d     = 1'b1;
      end
      CG_WAKE:  ack_d = 1'b0;
      default: begin
        gate_en_d = 1'b1;
        ack_d     = 1'b1;
      end
    endcase
  end

  assign clk_gate_en_o = gate_en_q;
  assign clk_en_ack_o  = ack_q;
  assign cluster_off_o = off_q;
  assign state_o       = state_q;

endmodule
